// File: rtl/sensor_scheduler.sv
// sensor_scheduler: ranges three HC-SR04 sensors one after another.
// Each sensor gets a trigger pulse, its echo width is converted to whole
// centimetres by a wrap counter, and a quiet guard time follows. The three
// results are collected in shadow registers and published together with a
// single frame_valid pulse at the end of the frame.
module sensor_scheduler #(
    parameter int CLK_HZ         = 50000000,
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int TIMEOUT_CYCLES = 1900000,
    parameter int GUARD_CYCLES   = 3000000,
    parameter int MAX_CM         = 400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        echo1,
    input  logic        echo2,
    input  logic        echo3,
    output logic        trig1,
    output logic        trig2,
    output logic        trig3,
    output logic [11:0] sens1,
    output logic [11:0] sens2,
    output logic [11:0] sens3,
    output logic        frame_valid,
    output logic [2:0]  err,
    output logic        busy
);

    // One shared phase counter covers trigger width, timeouts and guard time.
    localparam int CNT_MAX_A = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TRIG_CYCLES) ? CNT_MAX_A : TRIG_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    // Sub-counter counts echo cycles within one centimetre (CYCLES_PER_CM >= 2).
    localparam int SUB_W     = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [11:0]      CM_SAT     = 12'(MAX_CM);
    localparam logic [11:0]      CM_TIMEOUT = 12'hFFF;

    // The clock frequency only documents the cycle-count parameters.
    if (CLK_HZ <= 0) begin : g_clk_hz_unset
    end

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GUARD
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [11:0]       cm_q, cm_d;
    logic [2:0][11:0]  shadow_q, shadow_d;
    logic [2:0]        shadow_err_q, shadow_err_d;
    logic [2:0][11:0]  sens_q, sens_d;
    logic [2:0]        err_q, err_d;
    logic              fv_q, fv_d;
    logic [2:0]        trig_q, trig_d;
    logic [2:0]        echo_meta_q;
    logic [2:0]        echo_sync_q;
    logic              echo_sel;

    // Centimetre count that stops at the saturation value.
    function automatic logic [11:0] sat_inc(input logic [11:0] value);
        if (value >= CM_SAT) begin
            return CM_SAT;
        end
        return value + 12'd1;
    endfunction

    assign echo_sel = echo_sync_q[sel_q];

    // Two-flop synchronizer for the asynchronous echo inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_meta_q <= '0;
            echo_sync_q <= '0;
        end else begin
            echo_meta_q <= {echo3, echo2, echo1};
            echo_sync_q <= echo_meta_q;
        end
    end

    // State, counters, shadow results and published outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= 2'd0;
            cnt_q        <= '0;
            sub_q        <= '0;
            cm_q         <= 12'd0;
            shadow_q     <= '0;
            shadow_err_q <= 3'b000;
            sens_q       <= '0;
            err_q        <= 3'b000;
            fv_q         <= 1'b0;
            trig_q       <= 3'b000;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            sub_q        <= sub_d;
            cm_q         <= cm_d;
            shadow_q     <= shadow_d;
            shadow_err_q <= shadow_err_d;
            sens_q       <= sens_d;
            err_q        <= err_d;
            fv_q         <= fv_d;
            trig_q       <= trig_d;
        end
    end

    // Next-state logic: sequencing, echo measurement and frame publication.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        sub_d        = sub_q;
        cm_d         = cm_q;
        shadow_d     = shadow_q;
        shadow_err_d = shadow_err_q;
        sens_d       = sens_q;
        err_d        = err_q;
        fv_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = TRIG;
                end
            end

            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_RISE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_RISE: begin
                if (echo_sel) begin
                    // The cycle that sees the rise is the first high cycle.
                    cnt_d   = CNT_W'(1);
                    sub_d   = SUB_W'(1);
                    cm_d    = 12'd0;
                    state_d = MEASURE;
                end else if (cnt_q == TO_LAST) begin
                    shadow_d[sel_q]     = CM_TIMEOUT;
                    shadow_err_d[sel_q] = 1'b1;
                    cnt_d               = '0;
                    state_d             = GUARD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            MEASURE: begin
                if (!echo_sel) begin
                    shadow_d[sel_q]     = cm_q;
                    shadow_err_d[sel_q] = 1'b0;
                    cnt_d               = '0;
                    state_d             = GUARD;
                end else if (cnt_q == TO_LAST) begin
                    shadow_d[sel_q]     = CM_TIMEOUT;
                    shadow_err_d[sel_q] = 1'b1;
                    cnt_d               = '0;
                    state_d             = GUARD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        cm_d  = sat_inc(cm_q);
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
            end

            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d = '0;
                    if (sel_q == 2'd2) begin
                        // Publish all three results at once.
                        sens_d  = shadow_q;
                        err_d   = shadow_err_q;
                        fv_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        sel_d   = sel_q + 2'd1;
                        state_d = TRIG;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Trigger is registered from the next state so it is high exactly
        // while the FSM sits in TRIG, and only for the selected sensor.
        trig_d = (state_d == TRIG) ? (3'b001 << sel_d) : 3'b000;
    end

    assign trig1       = trig_q[0];
    assign trig2       = trig_q[1];
    assign trig3       = trig_q[2];
    assign sens1       = sens_q[0];
    assign sens2       = sens_q[1];
    assign sens3       = sens_q[2];
    assign err         = err_q;
    assign frame_valid = fv_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sensor_scheduler.sv
// tb_sensor_scheduler: directed bench for sensor_scheduler with small
// timing parameters and an echo responder that answers each trigger.
module tb_sensor_scheduler;

    localparam int TRIG_C  = 4;
    localparam int CPC     = 10;
    localparam int TO      = 2000;
    localparam int GD      = 20;
    localparam int MAXC    = 100;
    localparam int ECHO_DLY = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  echo_v;
    logic        trig1, trig2, trig3;
    logic [2:0]  trig_v;
    logic [11:0] sens1, sens2, sens3;
    logic        frame_valid;
    logic [2:0]  err;
    logic        busy;

    int checks;
    int errors;
    int width [3];

    int cyc;
    int fv_cnt;
    int overlap;
    int badw;
    int pulses [3];
    int run_len [3];
    int rise_t [3];
    int fall_t [3];

    assign trig_v = {trig3, trig2, trig1};

    always #5 clk = ~clk;

    sensor_scheduler #(
        .CLK_HZ(50000000),
        .TRIG_CYCLES(TRIG_C),
        .CYCLES_PER_CM(CPC),
        .TIMEOUT_CYCLES(TO),
        .GUARD_CYCLES(GD),
        .MAX_CM(MAXC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .echo1(echo_v[0]),
        .echo2(echo_v[1]),
        .echo3(echo_v[2]),
        .trig1(trig1),
        .trig2(trig2),
        .trig3(trig3),
        .sens1(sens1),
        .sens2(sens2),
        .sens3(sens3),
        .frame_valid(frame_valid),
        .err(err),
        .busy(busy)
    );

    // Echo responder: ECHO_DLY cycles after a trigger falls, drive echo high
    // for width[i] clock cycles (width 0 = sensor never answers).
    initial begin
        int dly [3];
        int rem [3];
        logic [2:0] prev;
        echo_v = 3'b000;
        prev = 3'b000;
        for (int i = 0; i < 3; i++) begin
            dly[i] = 0;
            rem[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (reset === 1'b1) begin
                    dly[i] = 0;
                    rem[i] = 0;
                    echo_v[i] = 1'b0;
                end else if (prev[i] === 1'b1 && trig_v[i] === 1'b0 && width[i] > 0) begin
                    dly[i] = ECHO_DLY;
                end else if (dly[i] > 0) begin
                    dly[i] = dly[i] - 1;
                    if (dly[i] == 0) begin
                        echo_v[i] = 1'b1;
                        rem[i] = width[i];
                    end
                end else if (rem[i] > 0) begin
                    rem[i] = rem[i] - 1;
                    if (rem[i] == 0) echo_v[i] = 1'b0;
                end
            end
            prev = trig_v;
        end
    end

    // Observer: frame_valid pulses, trigger pulse widths, overlap and edge times.
    initial begin
        logic [2:0] prev_m;
        prev_m = 3'b000;
        cyc = 0;
        fv_cnt = 0;
        overlap = 0;
        badw = 0;
        for (int i = 0; i < 3; i++) begin
            pulses[i] = 0;
            run_len[i] = 0;
            rise_t[i] = 0;
            fall_t[i] = 0;
        end
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if ($countones(trig_v) > 1) overlap = overlap + 1;
            for (int i = 0; i < 3; i++) begin
                if (trig_v[i] === 1'b1) begin
                    run_len[i] = run_len[i] + 1;
                    if (prev_m[i] !== 1'b1) begin
                        rise_t[i] = cyc;
                        pulses[i] = pulses[i] + 1;
                    end
                end else if (prev_m[i] === 1'b1) begin
                    fall_t[i] = cyc;
                    if (run_len[i] != TRIG_C) badw = badw + 1;
                    run_len[i] = 0;
                end
            end
            if (frame_valid === 1'b1) fv_cnt = fv_cnt + 1;
            prev_m = trig_v;
        end
    end

    task automatic start_frame();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_frame(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20000 && !got; i++) begin
            @(negedge clk);
            if (frame_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (trig_v !== 3'b000) begin errors++; $display("FAIL reset_trig: got %b expected 000", trig_v); end
        checks++; if (sens1 !== 12'd0) begin errors++; $display("FAIL reset_sens1: got %0d expected 0", sens1); end
        checks++; if (sens2 !== 12'd0) begin errors++; $display("FAIL reset_sens2: got %0d expected 0", sens2); end
        checks++; if (sens3 !== 12'd0) begin errors++; $display("FAIL reset_sens3: got %0d expected 0", sens3); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", err); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_enable_busy: got %b expected 0", busy); end
        checks++; if (trig_v !== 3'b000) begin errors++; $display("FAIL idle_no_enable_trig: got %b expected 000", trig_v); end
    endtask

    task automatic test_normal_frame();
        int fv0;
        bit got;
        width[0] = 250; width[1] = 100; width[2] = 9;
        fv0 = fv_cnt;
        start_frame();
        wait_frame(got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL normal_frame_seen: got %b expected 1", got); end
        checks++; if (sens1 !== 12'd25) begin errors++; $display("FAIL normal_sens1: got %0d expected 25", sens1); end
        checks++; if (sens2 !== 12'd10) begin errors++; $display("FAIL normal_sens2: got %0d expected 10", sens2); end
        checks++; if (sens3 !== 12'd0) begin errors++; $display("FAIL normal_sens3: got %0d expected 0", sens3); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL normal_err: got %b expected 000", err); end
        @(negedge clk);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL normal_fv_width: got %b expected 0", frame_valid); end
        repeat (30) @(negedge clk);
        checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL normal_fv_count: got %0d expected 1", fv_cnt - fv0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL normal_busy_after: got %b expected 0", busy); end
        checks++; if (sens1 !== 12'd25) begin errors++; $display("FAIL normal_hold_sens1: got %0d expected 25", sens1); end
    endtask

    task automatic test_no_echo();
        bit got;
        width[0] = 30; width[1] = 0; width[2] = 57;
        start_frame();
        wait_frame(got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL noecho_frame_seen: got %b expected 1", got); end
        checks++; if (sens1 !== 12'd3) begin errors++; $display("FAIL noecho_sens1: got %0d expected 3", sens1); end
        checks++; if (sens2 !== 12'hFFF) begin errors++; $display("FAIL noecho_sens2: got %h expected fff", sens2); end
        checks++; if (sens3 !== 12'd5) begin errors++; $display("FAIL noecho_sens3: got %0d expected 5", sens3); end
        checks++; if (err !== 3'b010) begin errors++; $display("FAIL noecho_err: got %b expected 010", err); end
        checks++; if (rise_t[2] - fall_t[1] !== TO + GD) begin errors++; $display("FAIL noecho_gap: got %0d expected %0d", rise_t[2] - fall_t[1], TO + GD); end
    endtask

    task automatic test_long_echo();
        bit got;
        bit low;
        width[0] = 5000; width[1] = 41; width[2] = 59;
        start_frame();
        wait_frame(got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL long_frame_seen: got %b expected 1", got); end
        checks++; if (sens1 !== 12'hFFF) begin errors++; $display("FAIL long_sens1: got %h expected fff", sens1); end
        checks++; if (sens2 !== 12'd4) begin errors++; $display("FAIL long_sens2: got %0d expected 4", sens2); end
        checks++; if (sens3 !== 12'd5) begin errors++; $display("FAIL long_sens3: got %0d expected 5", sens3); end
        checks++; if (err !== 3'b001) begin errors++; $display("FAIL long_err: got %b expected 001", err); end
        // trig1 fall -> echo seen 5 cycles later -> 2000 high cycles -> 20 guard
        checks++; if (rise_t[1] - fall_t[0] !== 2025) begin errors++; $display("FAIL long_timeout_gap: got %0d expected 2025", rise_t[1] - fall_t[0]); end
        low = 1'b0;
        for (int i = 0; i < 8000 && !low; i++) begin
            @(negedge clk);
            if (echo_v[0] === 1'b0) low = 1'b1;
        end
        checks++; if (low !== 1'b1) begin errors++; $display("FAIL long_echo_release: got %b expected 1", low); end
        width[0] = 1200;
        start_frame();
        wait_frame(got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL sat_frame_seen: got %b expected 1", got); end
        checks++; if (sens1 !== 12'd100) begin errors++; $display("FAIL sat_sens1: got %0d expected 100", sens1); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL sat_err: got %b expected 000", err); end
    endtask

    task automatic test_enable_drop();
        int p0 [3];
        int bw0;
        int ov0;
        int fv0;
        bit got;
        bit seen;
        width[0] = 60; width[1] = 70; width[2] = 80;
        for (int i = 0; i < 3; i++) p0[i] = pulses[i];
        bw0 = badw;
        ov0 = overlap;
        fv0 = fv_cnt;
        @(negedge clk);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (trig1 === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL endrop_trig1_seen: got %b expected 1", seen); end
        repeat (2) @(negedge clk);
        enable = 1'b0;
        wait_frame(got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL endrop_frame_seen: got %b expected 1", got); end
        checks++; if (sens1 !== 12'd6) begin errors++; $display("FAIL endrop_sens1: got %0d expected 6", sens1); end
        checks++; if (sens2 !== 12'd7) begin errors++; $display("FAIL endrop_sens2: got %0d expected 7", sens2); end
        checks++; if (sens3 !== 12'd8) begin errors++; $display("FAIL endrop_sens3: got %0d expected 8", sens3); end
        repeat (50) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL endrop_busy: got %b expected 0", busy); end
        checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL endrop_fv_count: got %0d expected 1", fv_cnt - fv0); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (pulses[i] - p0[i] !== 1) begin errors++; $display("FAIL endrop_trig%0d_pulses: got %0d expected 1", i + 1, pulses[i] - p0[i]); end
        end
        checks++; if (badw - bw0 !== 0) begin errors++; $display("FAIL trig_width: got %0d bad pulses expected 0", badw - bw0); end
        checks++; if (overlap - ov0 !== 0) begin errors++; $display("FAIL trig_overlap: got %0d cycles expected 0", overlap - ov0); end
    endtask

    task automatic test_reset_mid();
        int fv0;
        bit got;
        bit seen;
        width[0] = 30; width[1] = 100; width[2] = 30;
        start_frame();
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (trig2 === 1'b1) seen = 1'b1;
        end
        for (int i = 0; i < 20 && seen; i++) begin
            @(negedge clk);
            if (trig2 === 1'b0) seen = 1'b0;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_trig2_cycle: got %b expected 0", seen); end
        repeat (40) @(negedge clk);
        fv0 = fv_cnt;
        #2 reset = 1'b1;
        #1;
        checks++; if (sens1 !== 12'd0 || sens2 !== 12'd0 || sens3 !== 12'd0) begin errors++; $display("FAIL rstmid_sens: got %0d %0d %0d expected 0 0 0", sens1, sens2, sens3); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL rstmid_err: got %b expected 000", err); end
        checks++; if (trig_v !== 3'b000) begin errors++; $display("FAIL rstmid_trig: got %b expected 000", trig_v); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rstmid_fv: got %b expected 0", frame_valid); end
        repeat (120) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (fv_cnt !== fv0) begin errors++; $display("FAIL rstmid_no_fv: got %0d pulses expected 0", fv_cnt - fv0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_after: got %b expected 0", busy); end
        checks++; if (sens2 !== 12'd0) begin errors++; $display("FAIL rstmid_discard: got %0d expected 0", sens2); end
        width[0] = 70; width[1] = 80; width[2] = 90;
        start_frame();
        wait_frame(got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL rstmid_next_frame: got %b expected 1", got); end
        checks++; if (sens1 !== 12'd7) begin errors++; $display("FAIL rstmid_sens1: got %0d expected 7", sens1); end
        checks++; if (sens2 !== 12'd8) begin errors++; $display("FAIL rstmid_sens2: got %0d expected 8", sens2); end
        checks++; if (sens3 !== 12'd9) begin errors++; $display("FAIL rstmid_sens3: got %0d expected 9", sens3); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL rstmid_err_next: got %b expected 000", err); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        enable = 1'b0;
        reset = 1'b0;
        width[0] = 0; width[1] = 0; width[2] = 0;
        #1 reset = 1'b1;
        test_reset();
        test_normal_frame();
        test_no_echo();
        test_long_echo();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
